// File: rtl/bcd_uart_tx.sv
// -----------------------------------------------------------------------------
// bcd_uart_tx
//
// Sends a 3-digit packed BCD value over a UART transmit line. Each accepted
// start sends one 5-character line: hundreds, tens and units as ASCII, then
// CR and LF. The serial format is 8N1, LSB first, with a bit period of
// DIV = CLK_HZ/BAUD clock cycles.
//
// Parameters:
//   CLK_HZ   - clock frequency in Hz
//   BAUD     - bit rate; CLK_HZ/BAUD (truncated) must be at least 2
//   BLANK_LZ - 1: leading-zero digits are sent as a space; 0: sent as '0'
//
// Ports:
//   clk   - clock; all logic runs on its rising edge
//   rst   - asynchronous active-high reset; aborts any line in progress
//   bcd   - [11:8] hundreds, [7:4] tens, [3:0] units; captured when a start
//           is accepted
//   start - request to send one line; accepted only while busy is low
//   busy  - high while a line is being sent
//   done  - single-cycle pulse when the last stop bit of a line completes
//   txd   - serial output, idles high, driven straight from a register
// -----------------------------------------------------------------------------
module bcd_uart_tx #(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUD     = 115200,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        txd
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [2:0]       BIT_LAST  = 3'd7;
  localparam logic [2:0]       CHR_LAST  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [CNT_W-1:0] baud_d;
  logic [2:0]       bit_q;
  logic [2:0]       bit_d;
  logic [2:0]       chr_q;
  logic [2:0]       chr_d;
  logic [11:0]      bcd_q;
  logic             txd_q;
  logic             busy_q;
  logic             done_q;

  logic [7:0]       cur_chr;
  logic             baud_last;

  // One digit to ASCII. Digits A-F have no decimal glyph and become '?'.
  function automatic logic [7:0] digit_char(input logic [3:0] d,
                                            input logic       blank);
    logic [7:0] c;
    if (blank) begin
      c = 8'h20;
    end else if (d > 4'd9) begin
      c = 8'h3F;
    end else begin
      c = 8'h30 + {4'h0, d};
    end
    return c;
  endfunction

  // Character at position idx of the line. Blanking looks at the raw digit
  // value, so an invalid digit is nonzero and stops leading-zero blanking.
  // The units digit is never blanked so a value of zero still shows "0".
  function automatic logic [7:0] char_at(input logic [2:0]  idx,
                                         input logic [11:0] val);
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
    logic       h_zero;
    logic       t_zero;
    logic [7:0] c;
    h      = val[11:8];
    t      = val[7:4];
    u      = val[3:0];
    h_zero = (h == 4'd0);
    t_zero = (t == 4'd0);
    case (idx)
      3'd0:    c = digit_char(h, BLANK_LZ && h_zero);
      3'd1:    c = digit_char(t, BLANK_LZ && h_zero && t_zero);
      3'd2:    c = digit_char(u, 1'b0);
      3'd3:    c = 8'h0D;
      default: c = 8'h0A;
    endcase
    return c;
  endfunction

  always_comb begin
    cur_chr   = char_at(chr_q, bcd_q);
    baud_last = (baud_q == BAUD_LAST);
    baud_d    = baud_q + {{(CNT_W-1){1'b0}}, 1'b1};
    bit_d     = bit_q + 3'd1;
    chr_d     = chr_q + 3'd1;
  end

  // Transmit FSM. Every output is a register so txd cannot glitch. The
  // character byte for the next bit is looked up from the captured digits,
  // which lets the line continue unaffected by later changes on bcd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      chr_q   <= '0;
      bcd_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // busy is already low in the done cycle, so a start there is
          // accepted and the next start bit follows one idle-high cycle.
          if (start) begin
            bcd_q   <= bcd;
            chr_q   <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end

        S_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= cur_chr[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_d;
          end
        end

        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              bit_q   <= '0;
              txd_q   <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_d;
              txd_q <= cur_chr[bit_d];
            end
          end else begin
            baud_q <= baud_d;
          end
        end

        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (chr_q != CHR_LAST) begin
              chr_q   <= chr_d;
              txd_q   <= 1'b0;
              state_q <= S_START;
            end else begin
              chr_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_d;
          end
        end

        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          bit_q   <= '0;
          chr_q   <= '0;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign txd  = txd_q;

endmodule

// File: tb/tb_bcd_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_bcd_uart_tx
//
// Bench for bcd_uart_tx at CLK_HZ=16, BAUD=2 (8 cycles per bit). Two
// instances share bcd/start/rst: one with leading-zero blanking, one without.
// A UART receiver per instance decodes txd, checks every bit lasts exactly
// 8 cycles, and compares each byte with the scoreboard queue filled when
// the line was started. The main sequence checks busy/done/txd timing to
// the exact cycle.
// -----------------------------------------------------------------------------
module tb_bcd_uart_tx;

  localparam int DIV  = 8;
  localparam int LINE = 50 * DIV;

  logic        clk;
  logic        rst;
  logic [11:0] bcd;
  logic        start;
  logic        busy1;
  logic        done1;
  logic        txd1;
  logic        busy2;
  logic        done2;
  logic        txd2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  typedef struct packed {
    logic [11:0] bcd;
    logic [23:0] e1;   // H T U with blanking
    logic [23:0] e2;   // H T U without blanking
  } vec_t;

  vec_t vecs[8];

  bcd_uart_tx #(.CLK_HZ(16), .BAUD(2), .BLANK_LZ(1'b1)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .bcd   (bcd),
    .start (start),
    .busy  (busy1),
    .done  (done1),
    .txd   (txd1)
  );

  bcd_uart_tx #(.CLK_HZ(16), .BAUD(2), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk   (clk),
    .rst   (rst),
    .bcd   (bcd),
    .start (start),
    .busy  (busy2),
    .done  (done2),
    .txd   (txd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic rxbit(input int which);
    return (which == 0) ? txd1 : txd2;
  endfunction

  // st: 0 clean frame, 1 framing/timing error, 2 aborted by reset
  task automatic rx_frame(input int which, output int st, output logic [7:0] b);
    logic v;
    st = 0;
    b  = 8'h00;
    do begin
      @(negedge clk);
    end while (rst || rxbit(which) != 1'b0);
    for (int s = 1; s < DIV; s++) begin
      @(negedge clk);
      if (rst) begin st = 2; return; end
      if (rxbit(which) != 1'b0) st = 1;
    end
    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < DIV; s++) begin
        @(negedge clk);
        if (rst) begin st = 2; return; end
        v = rxbit(which);
        if (s == 0) b[i] = v;
        else if (v != b[i]) st = 1;
      end
    end
    for (int s = 0; s < DIV; s++) begin
      @(negedge clk);
      if (rst) begin st = 2; return; end
      if (rxbit(which) != 1'b1) st = 1;
    end
  endtask

  task automatic rx_mon(input int which);
    int         st;
    logic [7:0] b;
    logic [7:0] e;
    bit         empty;
    forever begin
      rx_frame(which, st, b);
      if (st != 2) begin
        checks++;
        empty = (which == 0) ? (q1.size() == 0) : (q2.size() == 0);
        if (empty) begin
          failures++;
          $display("FAIL rx%0d_unexpected actual=%h required=none", which, b);
        end else begin
          e = (which == 0) ? q1.pop_front() : q2.pop_front();
          if (b !== e || st != 0) begin
            failures++;
            $display("FAIL rx%0d_byte actual=%h framing_err=%0d required=%h t=%0t",
                     which, b, st, e, $time);
          end
        end
      end
    end
  endtask

  task automatic push_exp(input int vi);
    for (int j = 0; j < 3; j++) begin
      q1.push_back(vecs[vi].e1[23-8*j -: 8]);
      q2.push_back(vecs[vi].e2[23-8*j -: 8]);
    end
    q1.push_back(8'h0D); q1.push_back(8'h0A);
    q2.push_back(8'h0D); q2.push_back(8'h0A);
  endtask

  task automatic start_line(input int vi);
    @(negedge clk);
    bcd   = vecs[vi].bcd;
    start = 1'b1;
    push_exp(vi);
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_busy_txd_done", {29'd0, busy1, txd1, done1}, 32'b100);
  endtask

  // Follows one line from edge N (already passed) through edge N+LINE+1.
  task automatic track_line(input int ign_at, input int abort_at,
                            input int chain_vi);
    bit bad = 1'b0;
    for (int k = 1; k <= LINE; k++) begin
      @(posedge clk); #1;
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_now_txd_busy", {30'd0, txd1, busy1}, 32'b10);
        repeat (3) begin
          @(posedge clk); #1;
          if (done1 !== 1'b0 || busy1 !== 1'b0 || txd1 !== 1'b1 ||
              done2 !== 1'b0) bad = 1'b1;
        end
        chk("abort_hold_no_done", {31'd0, bad}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        q1.delete();
        q2.delete();
        return;
      end
      if (k == ign_at) begin
        bcd   = 12'h999;
        start = 1'b1;
      end
      if (ign_at > 0 && k == ign_at + 1) start = 1'b0;
      if (k == 10*DIV - 1) chk("stop0_still_high", {31'd0, txd1}, 32'd1);
      if (k == 10*DIV)     chk("chr1_start_edge", {31'd0, txd1}, 32'd0);
      if (k < LINE) begin
        if (busy1 !== 1'b1 || done1 !== 1'b0) bad = 1'b1;
      end else begin
        chk("done_pulse_busy_txd", {29'd0, done1, busy1, txd1}, 32'b101);
        chk("busy_window", {31'd0, bad}, 32'd0);
        if (chain_vi >= 0) begin
          bcd   = vecs[chain_vi].bcd;
          start = 1'b1;
          push_exp(chain_vi);
        end
      end
    end
    @(posedge clk); #1;
    chk("done_clear", {31'd0, done1}, 32'd0);
    if (chain_vi >= 0) begin
      start = 1'b0;
      chk("chain_start_busy_txd", {30'd0, busy1, txd1}, 32'b10);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      rx_mon(0);
      rx_mon(1);
    join_none
  end

  initial begin
    vecs[0] = '{12'h255, 24'h323535, 24'h323535};
    vecs[1] = '{12'h007, 24'h202037, 24'h303037};
    vecs[2] = '{12'h000, 24'h202030, 24'h303030};
    vecs[3] = '{12'h105, 24'h313035, 24'h313035};
    vecs[4] = '{12'h0A3, 24'h203F33, 24'h303F33};
    vecs[5] = '{12'h042, 24'h203432, 24'h303432};
    vecs[6] = '{12'hF0C, 24'h3F303F, 24'h3F303F};
    vecs[7] = '{12'h090, 24'h203930, 24'h303930};

    rst   = 1'b1;
    bcd   = 12'h000;
    start = 1'b0;
    #2;
    chk("reset_txd_busy_done", {28'd0, txd1, busy1, done1, txd2}, 32'b1001);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {29'd0, txd1, busy1, done1}, 32'b100);

    for (int i = 0; i < 8; i++) begin
      start_line(i);
      track_line(0, 0, -1);
    end

    // Ignored start mid-line with new bcd, then a start in the done cycle.
    start_line(0);
    track_line(100, 0, 5);
    track_line(0, 0, -1);

    // Reset part way through a line, then a clean line afterwards.
    start_line(0);
    track_line(0, 123, -1);
    repeat (2) @(negedge clk);
    chk("post_abort_idle", {29'd0, txd1, busy1, done1}, 32'b100);
    start_line(5);
    track_line(0, 0, -1);

    repeat (20) @(negedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_uart_tx.md
# bcd_uart_tx

Formats a 3-digit packed BCD value (hundreds/tens/units) as ASCII text and sends it out a UART transmit line. It sits directly downstream of the binary-to-BCD converter: the converter's 12-bit BCD output feeds `bcd`, and `txd` drives the board's serial pin. Each `start` sends one 5-character line: three digit characters, then CR and LF. Output is 8N1, LSB first.

## Interface
Parameters:
- `CLK_HZ`, default 50000000: clock frequency in Hz.
- `BAUD`, default 115200: bit rate. Bit period DIV = CLK_HZ/BAUD, truncated; DIV ≥ 2 required.
- `BLANK_LZ`, default 1: 1 = leading-zero digits sent as space (0x20); 0 = sent as '0'.

Ports:
- `clk`  in  1: single clock. Everything is synchronous to its rising edge.
- `rst`  in  1: reset. Asynchronous, active-high; it is the only asynchronous input.
- `bcd`  in  12: [11:8] hundreds, [7:4] tens, [3:0] units.
- `start`  in  1: request to send one line.
- `busy`  out  1: high while a line is in progress.
- `done`  out  1: one-cycle pulse when a line completes.
- `txd`  out  1: serial output; idles high.

## Operation
Reset values:
- `txd`=1, `busy`=0, `done`=0; FSM in IDLE; all counters 0.

Start acceptance:
- `start` is accepted only in a cycle where `busy`=0, including the cycle in which `done`=1.
- `start` while `busy`=1 is ignored and is not queued.
- On acceptance, `bcd` is captured into a holding register. Later changes to `bcd` do not affect the line in progress.

Character mapping, applied to the captured digits:
- Digit 0–9 → 0x30+digit.
- Digit A–F → '?' (0x3F). An invalid digit counts as nonzero for blanking.
- With BLANK_LZ=1:
  - Hundreds is blanked to a space if it is 0.
  - Tens is blanked to a space if both hundreds and tens are 0.
  - Units is never blanked.
- Every line is exactly 5 characters: H, T, U, 0x0D, 0x0A.

FSM states:
- IDLE → START: on accepted `start`.
- START: `txd`=0 for DIV cycles, then → DATA.
- DATA: 8 bits, LSB first, DIV cycles each. After bit 7 → STOP.
- STOP: `txd`=1 for DIV cycles. Then:
  - if characters remain, advance the character index → START;
  - otherwise pulse `done` → IDLE.

Counters:
- Baud counter counts 0..DIV-1 and restarts at each bit boundary.
- Bit index is 0..7; character index is 0..4.
- No wrap-around is visible outside the block.

Reset during a line:
- Aborts immediately (asynchronously): `txd`=1 and `busy`=0.
- No `done` pulse is produced.
- The partial character is not resumed after reset.

## Timing
- `start` is sampled high at edge N (with `busy`=0):
  - at edge N: `busy`=1, `txd`=0 (start bit begins);
  - at edge N+10·DIV: first stop bit ends, second character's start bit begins.
- Line length is 50·DIV cycles. At edge N+50·DIV: `done`=1, `busy`=0, `txd`=1. `done` returns to 0 at the next edge.
- Back-to-back lines: a `start` in the `done` cycle begins the next start bit at the following edge, giving one idle-high cycle between lines.
- `txd` is driven directly from a register (glitch-free).

## Test plan
Test setup: CLK_HZ=16, BAUD=2 (DIV=8). The bench decodes `txd` with a UART model and also checks bit edges to the exact cycle.

1. `bcd`=0x255, `start` pulse → bytes 0x32 0x35 0x35 0x0D 0x0A. `busy` high for exactly 400 cycles. Single `done` pulse at cycle 400.
2. BLANK_LZ=1, `bcd`=0x007 → 0x20 0x20 0x37 0x0D 0x0A. `bcd`=0x000 → 0x20 0x20 0x30 0x0D 0x0A. `bcd`=0x105 → 0x31 0x30 0x35 (inner zero kept).
3. BLANK_LZ=1, `bcd`=0x0A3 → 0x20 0x3F 0x33. BLANK_LZ=0, `bcd`=0x007 → 0x30 0x30 0x37.
4. `start` again at cycle 100 with `bcd` changed to 0x999 → ignored; the line still sends the captured value and only one `done`. A `start` in the `done` cycle → second line's start bit begins one cycle later.
5. Assert `rst` at cycle 123 of a line → `txd`=1 and `busy`=0 at once, no `done`. After release, `start` with `bcd`=0x042 → clean 0x20 0x34 0x32 0x0D 0x0A.
